// File: rtl/io_bus_fabric.sv
// Registered base/mask interconnect between the CPU data port and NSLV slave channels.
// One transaction in flight: IDLE decodes, WAIT holds s_req until ack or timeout, RESP pulses m_ack.
module io_bus_fabric #(
  parameter int NSLV = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_0000},
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [AW-1:0]     m_addr,
  input  logic [DW-1:0]     m_wd,
  input  logic [DW/8-1:0]   m_be,
  output logic [DW-1:0]     m_rd,
  output logic              m_ack,
  output logic              m_err,
  output logic [7:0]        err_cnt,
  output logic [NSLV-1:0]   s_req,
  output logic              s_we,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wd,
  output logic [DW/8-1:0]   s_be,
  input  logic [NSLV*DW-1:0] s_rd,
  input  logic [NSLV-1:0]   s_ack
);

  localparam int BW = DW / 8;
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSLV-1:0] s_req_q, s_req_d;
  logic            s_we_q, s_we_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wd_q, s_wd_d;
  logic [BW-1:0]   s_be_q, s_be_d;
  logic [DW-1:0]   m_rd_q, m_rd_d;
  logic            m_ack_q, m_ack_d;
  logic            m_err_q, m_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [NSLV-1:0] hit;
  logic [NSLV-1:0] hit_oh;
  logic [DW-1:0]   rd_slice [NSLV];
  logic [SW-1:0]   hit_idx;
  logic            any_hit;
  logic [7:0]      err_cnt_inc;

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
    assign hit[gi]      = (m_addr & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW];
    assign rd_slice[gi] = s_rd[gi*DW +: DW];
    assign hit_oh[gi]   = any_hit && (hit_idx == SW'(gi));
  end

  // Scanning downward lets the lowest hitting index win overlapping windows.
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_idx = SW'(k);
        any_hit = 1'b1;
      end
    end
  end

  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wd_d    = s_wd_q;
    s_be_d    = s_be_q;
    m_rd_d    = '0;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          if (any_hit) begin
            s_we_d   = m_we;
            s_addr_d = m_addr;
            s_wd_d   = m_wd;
            s_be_d   = m_be;
            sel_d    = hit_idx;
            cnt_d    = '0;
            s_req_d  = hit_oh;
            state_d  = ST_WAIT;
          end else begin
            m_ack_d   = 1'b1;
            m_err_d   = 1'b1;
            err_cnt_d = err_cnt_inc;
            state_d   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (s_ack[sel_q]) begin
          m_ack_d = 1'b1;
          m_rd_d  = s_we_q ? '0 : rd_slice[sel_q];
          s_req_d = '0;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          m_ack_d   = 1'b1;
          m_err_d   = 1'b1;
          err_cnt_d = err_cnt_inc;
          s_req_d   = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The response outputs are registered on entry to RESP, so they are high exactly while in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      s_req_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wd_q    <= '0;
      s_be_q    <= '0;
      m_rd_q    <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wd_q    <= s_wd_d;
      s_be_q    <= s_be_d;
      m_rd_q    <= m_rd_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_rd    = m_rd_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign err_cnt = err_cnt_q;
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wd    = s_wd_q;
  assign s_be    = s_be_q;

endmodule
